// File: rtl/irq_controller_if.sv
// Bus + interrupt handshake bundle between the CPU side and irq_controller.
interface irq_controller_if #(
    parameter int NSRC = 4,
    parameter int ID_W = 2
);
    logic [NSRC-1:0] src_irq;
    logic            kmode;
    logic            irq_req;
    logic [ID_W-1:0] irq_id;
    logic            irq_ack;
    logic            eret;
    logic [31:0]     addr;
    logic            rd;
    logic            wr;
    logic [31:0]     wdata;
    logic [31:0]     rdata;

    // CPU / system side
    modport master (
        output src_irq, kmode, irq_ack, eret, addr, rd, wr, wdata,
        input  irq_req, irq_id, rdata
    );

    // Controller side
    modport slave (
        input  src_irq, kmode, irq_ack, eret, addr, rd, wr, wdata,
        output irq_req, irq_id, rdata
    );
endinterface

// File: rtl/irq_controller.sv
// Edge-triggered interrupt controller: pending/mask/ctrl registers on the data
// bus, fixed-priority selection, and an IDLE/REQ/SERV request FSM.
module irq_controller #(
    parameter int          NSRC      = 4,
    parameter int          ID_W      = 2,
    parameter logic [31:0] BASE_ADDR = 32'h40000020
) (
    input logic              clk,
    input logic              reset,
    irq_controller_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_SERV = 2'd2;

    logic [NSRC-1:0] src_q, pend_q, pend_d, mask_q, mask_d;
    logic            gie_q, gie_d;
    logic [1:0]      state_q, state_d;
    logic [ID_W-1:0] id_q, id_d, cand;
    logic [NSRC-1:0] rise, elig, w1c, ack_clr;
    logic            sel, we_pend, we_mask, we_ctrl;
    logic [31:0]     reg_rd;
    logic            unused_bits;

    // Word-aligned access inside the 4-word block; low address bits select the register.
    assign sel     = (bus.addr[31:4] == BASE_ADDR[31:4]) && (bus.addr[1:0] == 2'b00);
    assign we_pend = bus.wr && sel && (bus.addr[3:2] == 2'd0);
    assign we_mask = bus.wr && sel && (bus.addr[3:2] == 2'd1);
    assign we_ctrl = bus.wr && sel && (bus.addr[3:2] == 2'd3);

    assign rise        = bus.src_irq & ~src_q;
    assign elig        = pend_q & mask_q;
    assign w1c         = we_pend ? bus.wdata[NSRC-1:0] : '0;
    assign unused_bits = ^bus.wdata;

    // Fixed priority: lowest eligible index wins.
    always_comb begin
        cand = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (elig[i]) cand = ID_W'(i);
    end

    // Request FSM; ack takes precedence over every withdraw reason.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        ack_clr = '0;
        case (state_q)
            S_IDLE: if (gie_q && !bus.kmode && |elig) begin
                state_d = S_REQ;
                id_d    = cand;
            end
            S_REQ: if (bus.irq_ack) begin
                state_d = S_SERV;
                ack_clr = NSRC'(1) << id_q;
            end else if (bus.kmode || !gie_q || !elig[id_q]) begin
                state_d = S_IDLE;
            end
            S_SERV: if (bus.eret) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Register next-state: a new edge beats any clear in the same cycle.
    always_comb begin
        pend_d = (pend_q & ~w1c & ~ack_clr) | rise;
        mask_d = we_mask ? bus.wdata[NSRC-1:0] : mask_q;
        gie_d  = we_ctrl ? bus.wdata[0] : gie_q;
    end

    // State and register storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_q   <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            gie_q   <= 1'b0;
            state_q <= S_IDLE;
            id_q    <= '0;
        end else begin
            src_q   <= bus.src_irq;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            gie_q   <= gie_d;
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

    // Combinational read mux; anything not addressed reads zero.
    always_comb begin
        reg_rd = '0;
        case (bus.addr[3:2])
            2'd0: reg_rd[NSRC-1:0] = pend_q;
            2'd1: reg_rd[NSRC-1:0] = mask_q;
            2'd2: begin
                reg_rd[31]       = (state_q == S_SERV);
                reg_rd[ID_W-1:0] = id_q;
            end
            default: reg_rd[0] = gie_q;
        endcase
    end

    assign bus.rdata   = (bus.rd && sel) ? reg_rd : 32'h0;
    assign bus.irq_req = (state_q == S_REQ);
    assign bus.irq_id  = id_q;
endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus random traffic,
// compared every cycle against a rule-level model of the controller.
module tb_irq_controller;
    localparam int          NSRC = 4;
    localparam int          ID_W = 2;
    localparam logic [31:0] BASE = 32'h40000020;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_pass = 0, n_total = 0;

    irq_controller_if #(.NSRC(NSRC), .ID_W(ID_W)) bus ();

    irq_controller #(.NSRC(NSRC), .ID_W(ID_W), .BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model state: pending set, enables, and whether a request / service is active.
    logic [3:0] m_src, m_pend, m_mask;
    logic       m_gie, m_req, m_serv;
    int         m_id;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic in_blk(input logic [31:0] a);
        return (a[31:4] == BASE[31:4]) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [31:0] m_rdata();
        if (!bus.rd || !in_blk(bus.addr)) return 32'h0;
        case (bus.addr[3:2])
            2'd0:    return {28'h0, m_pend};
            2'd1:    return {28'h0, m_mask};
            2'd2:    return {m_serv, 29'h0, m_id[1:0]};
            default: return {31'h0, m_gie};
        endcase
    endfunction

    task automatic model_step();
        logic [3:0] rise, clr, el;
        int k;
        rise = bus.src_irq & ~m_src;
        el   = m_pend & m_mask;
        clr  = 4'h0;
        if (bus.wr && in_blk(bus.addr) && bus.addr[3:2] == 2'd0) clr = bus.wdata[3:0];
        if (!m_req && !m_serv) begin
            if (m_gie && !bus.kmode && el != 4'h0) begin
                k = 0;
                while (!el[k]) k++;
                m_req = 1'b1;
                m_id  = k;
            end
        end else if (m_req) begin
            if (bus.irq_ack) begin
                m_req  = 1'b0;
                m_serv = 1'b1;
                clr[m_id] = 1'b1;
            end else if (bus.kmode || !m_gie || !el[m_id]) begin
                m_req = 1'b0;
            end
        end else if (bus.eret) begin
            m_serv = 1'b0;
        end
        m_pend = (m_pend & ~clr) | rise;
        if (bus.wr && in_blk(bus.addr) && bus.addr[3:2] == 2'd1) m_mask = bus.wdata[3:0];
        if (bus.wr && in_blk(bus.addr) && bus.addr[3:2] == 2'd3) m_gie = bus.wdata[0];
        m_src = bus.src_irq;
    endtask

    // Model advances on every clock edge and resets asynchronously with the DUT.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_src = 4'h0; m_pend = 4'h0; m_mask = 4'h0;
            m_gie = 1'b0; m_req = 1'b0; m_serv = 1'b0; m_id = 0;
        end else begin
            model_step();
        end
    end

    // Per-cycle comparison, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            chk("irq_req", {31'h0, bus.irq_req}, {31'h0, m_req});
            if (m_req || m_serv) chk("irq_id", {30'h0, bus.irq_id}, {30'h0, m_id[1:0]});
            chk("rdata", bus.rdata, m_rdata());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wreg(input int off, input logic [31:0] d);
        bus.addr = BASE + 32'(off * 4); bus.wdata = d; bus.wr = 1'b1;
        tick();
        bus.wr = 1'b0;
    endtask

    task automatic rreg(input int off, output logic [31:0] v);
        bus.addr = BASE + 32'(off * 4); bus.rd = 1'b1;
        #1 v = bus.rdata;
        bus.rd = 1'b0;
    endtask

    task automatic serve();
        bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
        bus.eret = 1'b1;    tick(); bus.eret = 1'b0;
    endtask

    logic [31:0] v;
    int          r, k;

    initial begin
        bus.src_irq = '0; bus.kmode = 1'b0; bus.irq_ack = 1'b0; bus.eret = 1'b0;
        bus.addr = 32'h0; bus.rd = 1'b0; bus.wr = 1'b0; bus.wdata = 32'h0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        tick();

        // Reset state
        chk("rst_req", {31'h0, bus.irq_req}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            rreg(i, v);
            chk("rst_reg", v, 32'h0);
        end

        // T1: single source, two-edge latency, ack clears pending
        wreg(3, 32'h1);
        wreg(1, 32'h2);
        bus.src_irq = 4'b0010; tick();
        bus.src_irq = 4'b0000;
        chk("t1_early", {31'h0, bus.irq_req}, 32'h0);
        tick();
        chk("t1_req", {31'h0, bus.irq_req}, 32'h1);
        chk("t1_id", {30'h0, bus.irq_id}, 32'h1);
        bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
        rreg(0, v); chk("t1_pend", v, 32'h0);
        rreg(2, v); chk("t1_cur", v, 32'h80000001);
        bus.eret = 1'b1; tick(); bus.eret = 1'b0;
        rreg(2, v); chk("t1_cur_done", v, 32'h00000001);

        // T2: simultaneous arrivals, lowest index first
        wreg(1, 32'hF);
        bus.src_irq = 4'b1001; tick();
        bus.src_irq = 4'b0000; tick();
        chk("t2_id0", {30'h0, bus.irq_id}, 32'h0);
        serve();
        tick();
        chk("t2_req3", {31'h0, bus.irq_req}, 32'h1);
        chk("t2_id3", {30'h0, bus.irq_id}, 32'h3);
        serve();

        // T3: software clears the requested bit -> withdraw
        bus.src_irq = 4'b0100; tick();
        bus.src_irq = 4'b0000; tick();
        chk("t3_req", {31'h0, bus.irq_req}, 32'h1);
        wreg(0, 32'h4);
        tick();
        chk("t3_drop", {31'h0, bus.irq_req}, 32'h0);
        rreg(2, v); chk("t3_cur", {31'h0, v[31]}, 32'h0);

        // T4: kernel mode blocks new requests
        wreg(1, 32'h1);
        bus.kmode = 1'b1;
        bus.src_irq = 4'b0001; tick();
        bus.src_irq = 4'b0000;
        repeat (3) tick();
        chk("t4_blocked", {31'h0, bus.irq_req}, 32'h0);
        bus.kmode = 1'b0; tick();
        chk("t4_req", {31'h0, bus.irq_req}, 32'h1);
        chk("t4_id", {30'h0, bus.irq_id}, 32'h0);
        serve();

        // T5: new edge beats W1C in the same cycle
        wreg(1, 32'h0);
        bus.src_irq = 4'b0100; tick();
        bus.src_irq = 4'b0000; tick();
        bus.src_irq = 4'b0100;
        wreg(0, 32'h4);
        bus.src_irq = 4'b0000;
        rreg(0, v); chk("t5_pend", v, 32'h4);
        wreg(0, 32'h4);
        rreg(0, v); chk("t5_clear", v, 32'h0);

        // T6: async reset in the middle of a request
        wreg(1, 32'hF);
        bus.src_irq = 4'b0010; tick();
        bus.src_irq = 4'b0000; tick();
        chk("t6_req", {31'h0, bus.irq_req}, 32'h1);
        #1 reset = 1'b0;
        #1 chk("t6_req_async", {31'h0, bus.irq_req}, 32'h0);
        chk("t6_id", {30'h0, bus.irq_id}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            rreg(i, v);
            chk("t6_reg", v, 32'h0);
        end
        @(posedge clk);
        #3 reset = 1'b1;
        tick();

        // Random traffic
        wreg(3, 32'h1);
        wreg(1, 32'hF);
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < NSRC; b++)
                if ($urandom_range(0, 7) == 0) bus.src_irq[b] = ~bus.src_irq[b];
            if ($urandom_range(0, 19) == 0) bus.kmode = ~bus.kmode;
            bus.irq_ack = ($urandom_range(0, 2) == 0);
            bus.eret    = ($urandom_range(0, 3) == 0);
            k = $urandom_range(0, 6);
            case (k)
                4:       bus.addr = BASE + 32'h10;
                5:       bus.addr = BASE - 32'h4;
                6:       bus.addr = $urandom() & 32'hFFFFFFFC;
                default: bus.addr = BASE + 32'(k * 4);
            endcase
            r = $urandom_range(0, 7);
            bus.wr = (r == 0);
            bus.rd = (r >= 1 && r <= 3);
            bus.wdata = (k == 3) ? {31'h0, ($urandom_range(0, 3) != 0)} : $urandom();
            tick();
        end
        bus.wr = 1'b0; bus.rd = 1'b0; bus.irq_ack = 1'b0; bus.eret = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
